// File: rtl/exu_pkg.sv
// Shared types for the execute-stage scheduler: FSM state encoding and result-mux selects.
// Pure declarations; no logic, no latency, no flow control.
package exu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_WAIT = 2'd1,
      ST_DIV_WAIT = 2'd2
   } exu_state_t;

   localparam logic [1:0] RES_ALU = 2'd0;
   localparam logic [1:0] RES_MUL = 2'd1;
   localparam logic [1:0] RES_DIV = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// Updates one cycle after i_inc; no flow control.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/exu_sched.sv
// EX-stage scheduler: ALU results pass through in zero cycles, mul/div are issued and waited on.
// exu_idle holds ID/EX while a unit op is pending or EX/MEM withholds out_ready; flush aborts.
module exu_sched
   import exu_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 128
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_in_valid,
   input  logic             i_in_mul_valid,
   input  logic             i_in_div_valid,
   input  logic             i_out_ready,
   input  logic             i_mul_ready,
   input  logic             i_div_ready,
   input  logic             i_mul_out_valid,
   input  logic             i_div_out_valid,
   output logic             o_exu_idle,
   output logic             o_out_valid,
   output logic [1:0]       o_res_sel,
   output logic             o_mul_start,
   output logic             o_div_start,
   output logic             o_mul_out_ready,
   output logic             o_div_out_ready,
   output logic             o_mul_flush,
   output logic             o_div_flush,
   output logic [CNT_W-1:0] o_mul_cycles,
   output logic [CNT_W-1:0] o_div_cycles,
   output logic             o_timeout_err
);

   localparam int                WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] TO_M1  = WAIT_W'(TIMEOUT - 1);

   exu_state_t        r_state;
   exu_state_t        w_next;
   logic              r_timeout_err;
   logic [WAIT_W-1:0] w_wait_cnt;
   logic              w_in_wait;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next          = r_state;
      o_exu_idle      = 1'b1;
      o_out_valid     = 1'b0;
      o_res_sel       = RES_ALU;
      o_mul_start     = 1'b0;
      o_div_start     = 1'b0;
      o_mul_out_ready = 1'b0;
      o_div_out_ready = 1'b0;
      o_mul_flush     = 1'b0;
      o_div_flush     = 1'b0;
      if (i_flush) begin
         // A result arriving alongside the flush is dropped; the abort pulse tells the unit.
         w_next      = ST_IDLE;
         o_mul_flush = (r_state == ST_MUL_WAIT);
         o_div_flush = (r_state == ST_DIV_WAIT);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_in_valid) begin
                  if (i_in_mul_valid) begin
                     o_exu_idle  = 1'b0;
                     o_mul_start = 1'b1;
                     if (i_mul_ready) w_next = ST_MUL_WAIT;
                  end else if (i_in_div_valid) begin
                     o_exu_idle  = 1'b0;
                     o_div_start = 1'b1;
                     if (i_div_ready) w_next = ST_DIV_WAIT;
                  end else begin
                     o_out_valid = 1'b1;
                  end
               end
            end
            ST_MUL_WAIT: begin
               o_res_sel       = RES_MUL;
               o_out_valid     = i_mul_out_valid;
               o_mul_out_ready = i_out_ready;
               o_exu_idle      = i_mul_out_valid & i_out_ready;
               if (i_mul_out_valid && i_out_ready) w_next = ST_IDLE;
            end
            ST_DIV_WAIT: begin
               o_res_sel       = RES_DIV;
               o_out_valid     = i_div_out_valid;
               o_div_out_ready = i_out_ready;
               o_exu_idle      = i_div_out_valid & i_out_ready;
               if (i_div_out_valid && i_out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   assign w_in_wait = (r_state != ST_IDLE);

   sat_counter #(.W(CNT_W)) u_mul_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (1'b0),
      .i_inc (r_state == ST_MUL_WAIT),
      .o_cnt (o_mul_cycles)
   );

   sat_counter #(.W(CNT_W)) u_div_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (1'b0),
      .i_inc (r_state == ST_DIV_WAIT),
      .o_cnt (o_div_cycles)
   );

   // Cleared on the dispatch edge so each wait starts counting from zero.
   sat_counter #(.W(WAIT_W)) u_wait_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (!w_in_wait && (w_next != ST_IDLE)),
      .i_inc (w_in_wait),
      .o_cnt (w_wait_cnt)
   );

   // Sets on the edge that completes the TIMEOUT-th wait cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_timeout_err <= 1'b0;
      end else if (w_in_wait && (w_wait_cnt >= TO_M1)) begin
         r_timeout_err <= 1'b1;
      end
   end

   assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_exu_sched.sv
// Directed bench for exu_sched with CNT_W=3, TIMEOUT=4 so saturation and watchdog are reachable.
module tb_exu_sched;
   import exu_pkg::*;

   logic       clk = 1'b0;
   logic       rst, flush, in_valid, in_mul_valid, in_div_valid, out_ready;
   logic       mul_ready, div_ready, mul_out_valid, div_out_valid;
   logic       exu_idle, out_valid, mul_start, div_start;
   logic       mul_out_ready, div_out_ready, mul_flush, div_flush, timeout_err;
   logic [1:0] res_sel;
   logic [2:0] mul_cycles, div_cycles;

   int n_asrt = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   exu_sched #(.CNT_W(3), .TIMEOUT(4)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_flush         (flush),
      .i_in_valid      (in_valid),
      .i_in_mul_valid  (in_mul_valid),
      .i_in_div_valid  (in_div_valid),
      .i_out_ready     (out_ready),
      .i_mul_ready     (mul_ready),
      .i_div_ready     (div_ready),
      .i_mul_out_valid (mul_out_valid),
      .i_div_out_valid (div_out_valid),
      .o_exu_idle      (exu_idle),
      .o_out_valid     (out_valid),
      .o_res_sel       (res_sel),
      .o_mul_start     (mul_start),
      .o_div_start     (div_start),
      .o_mul_out_ready (mul_out_ready),
      .o_div_out_ready (div_out_ready),
      .o_mul_flush     (mul_flush),
      .o_div_flush     (div_flush),
      .o_mul_cycles    (mul_cycles),
      .o_div_cycles    (div_cycles),
      .o_timeout_err   (timeout_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mul_valid = 1'b0; in_div_valid = 1'b0;
      out_ready = 1'b0; mul_ready = 1'b0; div_ready = 1'b0;
      mul_out_valid = 1'b0; div_out_valid = 1'b0;
      do_reset();

      // Reset state
      chk("rst_idle", exu_idle, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_res_sel", res_sel, 0);
      chk("rst_mul_start", mul_start, 0);
      chk("rst_mul_cycles", mul_cycles, 0);
      chk("rst_div_cycles", div_cycles, 0);
      chk("rst_timeout", timeout_err, 0);

      // ALU op: same-cycle result
      in_valid = 1'b1;
      #1;
      chk("alu_out_valid", out_valid, 1);
      chk("alu_res_sel", res_sel, RES_ALU);
      chk("alu_idle", exu_idle, 1);
      chk("alu_mul_start", mul_start, 0);
      chk("alu_mul_cycles", mul_cycles, 0);
      tick();

      // Mul op issued immediately, result on the 5th wait cycle
      in_mul_valid = 1'b1; mul_ready = 1'b1;
      #1;
      chk("mul_issue_start", mul_start, 1);
      chk("mul_issue_idle", exu_idle, 0);
      tick();
      mul_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("mul_wait_idle", exu_idle, 0);
         chk("mul_wait_res_sel", res_sel, RES_MUL);
         chk("mul_wait_out_valid", out_valid, 0);
         chk("mul_wait_start", mul_start, 0);
         tick();
      end
      mul_out_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("mul_done_out_valid", out_valid, 1);
      chk("mul_done_idle", exu_idle, 1);
      chk("mul_done_out_ready", mul_out_ready, 1);
      chk("mul_done_res_sel", res_sel, RES_MUL);
      tick();
      in_valid = 1'b0; in_mul_valid = 1'b0; mul_out_valid = 1'b0;
      #1;
      chk("mul_after_res_sel", res_sel, RES_ALU);
      chk("mul_after_out_valid", out_valid, 0);
      chk("mul_cycles_5", mul_cycles, 5);
      chk("mul5_timeout", timeout_err, 1);

      do_reset();
      chk("rst2_timeout", timeout_err, 0);
      chk("rst2_mul_cycles", mul_cycles, 0);

      // Div op stalled by div_ready for 3 cycles
      in_valid = 1'b1; in_div_valid = 1'b1; div_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("div_stall_start", div_start, 1);
         chk("div_stall_idle", exu_idle, 0);
         chk("div_stall_res_sel", res_sel, RES_ALU);
         chk("div_stall_cycles", div_cycles, 0);
         tick();
      end
      div_ready = 1'b1;
      #1;
      chk("div_accept_start", div_start, 1);
      tick();
      div_ready = 1'b0;
      #1;
      chk("div_wait_res_sel", res_sel, RES_DIV);
      chk("div_wait_start", div_start, 0);
      chk("div_wait_idle", exu_idle, 0);
      tick();

      // Flush in DIV_WAIT coincident with a div result
      flush = 1'b1; div_out_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("flush_div_flush", div_flush, 1);
      chk("flush_mul_flush", mul_flush, 0);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_idle", exu_idle, 1);
      tick();
      flush = 1'b0; in_valid = 1'b0; in_div_valid = 1'b0;
      #1;
      chk("postflush_div_flush", div_flush, 0);
      chk("postflush_out_valid", out_valid, 0);
      chk("postflush_res_sel", res_sel, RES_ALU);
      chk("postflush_div_cycles", div_cycles, 2);
      div_out_valid = 1'b0;

      // Watchdog: mul never returns for 5 wait cycles
      in_valid = 1'b1; in_mul_valid = 1'b1; mul_ready = 1'b1;
      tick();
      mul_ready = 1'b0;
      tick();
      tick();
      chk("wd_w3_timeout", timeout_err, 0);
      tick();
      chk("wd_w4_timeout", timeout_err, 0);
      tick();
      chk("wd_w5_timeout", timeout_err, 1);
      chk("wd_w5_res_sel", res_sel, RES_MUL);
      mul_out_valid = 1'b1;
      tick();
      in_valid = 1'b0; in_mul_valid = 1'b0; mul_out_valid = 1'b0;
      #1;
      chk("wd_done_timeout", timeout_err, 1);
      chk("wd_done_res_sel", res_sel, RES_ALU);
      chk("wd_mul_cycles", mul_cycles, 5);

      do_reset();
      chk("rst3_timeout", timeout_err, 0);

      // Mul wins when both op flags are set
      in_valid = 1'b1; in_mul_valid = 1'b1; in_div_valid = 1'b1;
      #1;
      chk("prio_mul_start", mul_start, 1);
      chk("prio_div_start", div_start, 0);
      in_div_valid = 1'b0;

      // Back-to-back 1-cycle muls: counter saturates at 7
      mul_ready = 1'b1; mul_out_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      chk("sat_mul_cycles_6", mul_cycles, 6);
      chk("sat_issue_idle", exu_idle, 0);
      for (int i = 0; i < 4; i++) tick();
      chk("sat_mul_cycles_7", mul_cycles, 7);
      for (int i = 0; i < 4; i++) tick();
      chk("sat_mul_cycles_hold", mul_cycles, 7);
      chk("sat_timeout", timeout_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/exu_sched.md
# exu_sched

Execute-stage scheduler sitting between the ID/EX pipeline register and the EX/MEM stage. Classifies the instruction held in ID/EX as single-cycle ALU, multiply or divide, issues multi-cycle ops to the shared multiplier/divider via valid/ready handshakes, and drives `exu_idle` back to ID/EX so the register holds while a multi-cycle op is in flight. Also handles pipeline flush of in-flight mul/div, saturating busy-cycle counters and a sticky watchdog error.

## Interface
- `CNT_W`, default 32: width of the mul/div busy-cycle counters (saturating).
- `TIMEOUT`, default 128: wait cycles after which `timeout_err` sets.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  squash current EX instruction.
- `in_valid`  in  1  ID/EX holds a valid instruction.
- `in_mul_valid`  in  1  instruction is a multiply.
- `in_div_valid`  in  1  instruction is a divide.
- `out_ready`  in  1  EX/MEM can accept a result.
- `mul_ready`, `div_ready`  in  1 each  unit accepts a start.
- `mul_out_valid`, `div_out_valid`  in  1 each  unit result available, held until acked.
- `exu_idle`  out  1  to ID/EX; high = ID/EX may advance.
- `out_valid`  out  1  EX result valid to EX/MEM.
- `res_sel`  out  2  result mux: 0 ALU, 1 MUL, 2 DIV.
- `mul_start`, `div_start`  out  1 each  issue request (valid).
- `mul_out_ready`, `div_out_ready`  out  1 each  result ack.
- `mul_flush`, `div_flush`  out  1 each  one-cycle abort pulse.
- `mul_cycles`, `div_cycles`  out  CNT_W each  cumulative cycles spent in MUL_WAIT/DIV_WAIT.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- States: IDLE, MUL_WAIT, DIV_WAIT.
- IDLE, no `in_valid`: `exu_idle`=1, `out_valid`=0, `res_sel`=0.
- IDLE, ALU op (`in_valid`, neither mul/div): `out_valid`=1, `res_sel`=0, `exu_idle`=1; stay IDLE.
- IDLE, mul op: `exu_idle`=0, `mul_start`=1; if `mul_ready` -> MUL_WAIT, else stay IDLE (ID/EX held, request repeats). Div identical with div signals -> DIV_WAIT.
- `in_mul_valid` and `in_div_valid` both high: mul wins.
- MUL_WAIT: `res_sel`=1, `out_valid`=`mul_out_valid`, `mul_out_ready`=`out_ready`, `exu_idle`=`mul_out_valid & out_ready`; on that handshake -> IDLE. DIV_WAIT symmetric (`res_sel`=2).
- `flush` (highest priority, any state): `out_valid`=0, `mul_start`/`div_start`=0, `exu_idle`=1; in MUL_WAIT pulse `mul_flush`, in DIV_WAIT pulse `div_flush`; next state IDLE. Completion in the same cycle is discarded.
- Counters: `mul_cycles` +1 each cycle in MUL_WAIT, `div_cycles` in DIV_WAIT; saturate at all-ones, never wrap.
- Watchdog: `wait_cnt` cleared on entering a WAIT state, +1 per WAIT cycle; reaching `TIMEOUT` sets `timeout_err`, cleared only by `rst`. FSM keeps waiting.

## Timing
- Reset: state IDLE, counters/`wait_cnt` 0, `timeout_err` 0; outputs then follow IDLE rules (`exu_idle`=1, all others 0 absent inputs).
- All handshake outputs combinational from state + inputs; no registered output delay.
- ALU: zero added latency, result in same cycle as `in_valid`.
- Mul issued cycle T (`mul_ready`=1): MUL_WAIT from T+1; unit result at T+k with `out_ready` -> `out_valid`/`exu_idle` high at T+k, IDLE at T+k+1, next instruction may dispatch at T+k+1 (back-to-back supported).
- `out_ready` low with result valid: stay in WAIT, outputs held; watchdog still counts.
- Reset mid-WAIT: immediate IDLE, no flush pulse required (units reset by `rst` too).

## Structure
- Shared package `exu_pkg`: state encoding constants (IDLE=0, MUL_WAIT=1, DIV_WAIT=2), `res_sel` constants (RES_ALU/RES_MUL/RES_DIV).
- One sub-module: `sat_counter` (parameterised width, `clr`, `inc`), instantiated for `mul_cycles`, `div_cycles`, `wait_cnt`.

## Test plan
- Reset then `in_valid`=1 ALU op -> same cycle `out_valid`=1, `res_sel`=0, `exu_idle`=1, `mul_cycles`=0.
- Mul op, `mul_ready`=1, result after 5 cycles with `out_ready`=1 -> `exu_idle`=0 for 5 cycles, `mul_cycles`=5, IDLE afterward.
- Div op with `div_ready` low 3 cycles -> `div_start` held 3+1 cycles, DIV_WAIT entered only after ready; `div_cycles` not counting during stall.
- Flush in DIV_WAIT coincident with `div_out_valid` -> `div_flush`=1 one cycle, `out_valid`=0, IDLE next cycle.
- `TIMEOUT`=4, mul never returns -> `timeout_err`=1 after 4 WAIT cycles, remains 1 after later completion until `rst`.
- `CNT_W`=3, eight mul waits of 1 cycle each -> `mul_cycles` saturates at 7.
